// File: rtl/dsa_host_seq.sv
// dsa_host_seq: bus initiator that programs, feeds, polls and drains one DSA downscale job
module dsa_host_seq #(
  parameter int ADDR_WIDTH   = 16,
  parameter int IN_GAP       = 4,
  parameter int START_SETTLE = 8,
  parameter int POLL_GAP     = 16,
  parameter int TIMEOUT      = 2**20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  job_start,
  input  logic [15:0]           job_img_w,
  input  logic [15:0]           job_img_h,
  input  logic [15:0]           job_scale,
  input  logic [15:0]           job_in_words,
  input  logic [15:0]           job_out_pix,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [31:0]           perf_cyc,
  output logic [31:0]           perf_pix,
  output logic                  h_wr_en,
  output logic                  h_rd_en,
  output logic [ADDR_WIDTH-1:0] h_addr,
  output logic [31:0]           h_wdata,
  input  logic [31:0]           h_rdata,
  input  logic                  h_rvalid
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [4:0] {
    S_IDLE, S_WR_W, S_WR_H, S_WR_SCALE, S_WR_INADDR, S_IN_WAIT, S_IN_WR, S_IN_GAP,
    S_WR_START, S_SETTLE, S_POLL_PRIME, S_POLL_RD, S_POLL_WAIT, S_CYC_PRIME, S_CYC_RD,
    S_PIX_PRIME, S_PIX_RD, S_WR_OUTADDR, S_OUT_RD, S_OUT_HOLD, S_FIN
  } state_t;
  state_t state, state_n;
  logic [15:0] img_w, img_h, scale, in_words, out_pix, wcnt, pcnt, cnt;
  logic [TW-1:0] tcnt;
  logic in_poll, tout, cap, cap_o, wr_n, rd_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [31:0] wdata_n;
  assign in_poll  = state inside {S_SETTLE, S_POLL_PRIME, S_POLL_RD, S_POLL_WAIT};
  assign tout     = in_poll && tcnt == TW'(TIMEOUT - 1);
  assign cap      = h_rvalid && cnt >= 16'd2;
  assign cap_o    = h_rvalid && cnt != 16'd0;
  assign in_ready = state == S_IN_WAIT;
  assign busy     = state != S_IDLE && state != S_FIN;
  assign done     = state == S_FIN;
  // state register
  always_ff @(posedge clk)
    state <= rst ? S_IDLE : state_n;
  // next-state: sequence of bus phases; a poll timeout overrides everything
  always_comb begin
    state_n = state;
    if (tout) state_n = S_IDLE;
    else
      case (state)
        S_IDLE:       state_n = job_start ? S_WR_W : S_IDLE;
        S_WR_W:       state_n = S_WR_H;
        S_WR_H:       state_n = S_WR_SCALE;
        S_WR_SCALE:   state_n = S_WR_INADDR;
        S_WR_INADDR:  state_n = in_words == 16'd0 ? S_WR_START : S_IN_WAIT;
        S_IN_WAIT:    state_n = in_valid ? S_IN_WR : S_IN_WAIT;
        S_IN_WR:      state_n = S_IN_GAP;
        S_IN_GAP:     state_n = cnt != 16'(IN_GAP - 1) ? S_IN_GAP : wcnt == in_words ? S_WR_START : S_IN_WAIT;
        S_WR_START:   state_n = S_SETTLE;
        S_SETTLE:     state_n = cnt == 16'(START_SETTLE - 1) ? S_POLL_PRIME : S_SETTLE;
        S_POLL_PRIME: state_n = S_POLL_RD;
        S_POLL_RD:    state_n = !cap ? S_POLL_RD : h_rdata[1] ? S_CYC_PRIME : S_POLL_WAIT;
        S_POLL_WAIT:  state_n = cnt == 16'(POLL_GAP - 1) ? S_POLL_PRIME : S_POLL_WAIT;
        S_CYC_PRIME:  state_n = S_CYC_RD;
        S_CYC_RD:     state_n = cap ? S_PIX_PRIME : S_CYC_RD;
        S_PIX_PRIME:  state_n = S_PIX_RD;
        S_PIX_RD:     state_n = cap ? S_WR_OUTADDR : S_PIX_RD;
        S_WR_OUTADDR: state_n = out_pix == 16'd0 ? S_FIN : S_OUT_RD;
        S_OUT_RD:     state_n = cap_o ? S_OUT_HOLD : S_OUT_RD;
        S_OUT_HOLD:   state_n = !out_ready ? S_OUT_HOLD : pcnt + 16'd1 == out_pix ? S_FIN : S_OUT_RD;
        default:      state_n = S_IDLE;
      endcase
  end
  // bus request for the next cycle; capture reads go out on the second cycle of an *_RD state
  always_comb begin
    wr_n = 1'b0;
    rd_n = 1'b0;
    addr_n = '0;
    wdata_n = '0;
    if (!tout)
      case (state)
        S_WR_W:       begin wr_n = 1'b1; addr_n = ADDR_WIDTH'(8'h02); wdata_n = {16'd0, img_w}; end
        S_WR_H:       begin wr_n = 1'b1; addr_n = ADDR_WIDTH'(8'h03); wdata_n = {16'd0, img_h}; end
        S_WR_SCALE:   begin wr_n = 1'b1; addr_n = ADDR_WIDTH'(8'h04); wdata_n = {16'd0, scale}; end
        S_WR_INADDR:  begin wr_n = 1'b1; addr_n = ADDR_WIDTH'(8'h20); end
        S_IN_WAIT:    begin wr_n = in_valid; addr_n = ADDR_WIDTH'(8'h21); wdata_n = in_data; end
        S_WR_START:   begin wr_n = 1'b1; addr_n = ADDR_WIDTH'(8'h00); wdata_n = 32'd1; end
        S_POLL_PRIME: begin rd_n = 1'b1; addr_n = ADDR_WIDTH'(8'h01); end
        S_POLL_RD:    begin rd_n = cnt == 16'd1; addr_n = ADDR_WIDTH'(8'h01); end
        S_CYC_PRIME:  begin rd_n = 1'b1; addr_n = ADDR_WIDTH'(8'h06); end
        S_CYC_RD:     begin rd_n = cnt == 16'd1; addr_n = ADDR_WIDTH'(8'h06); end
        S_PIX_PRIME:  begin rd_n = 1'b1; addr_n = ADDR_WIDTH'(8'h07); end
        S_PIX_RD:     begin rd_n = cnt == 16'd1; addr_n = ADDR_WIDTH'(8'h07); end
        S_WR_OUTADDR: begin wr_n = 1'b1; addr_n = ADDR_WIDTH'(8'h30); end
        S_OUT_RD:     begin rd_n = cnt == 16'd0; addr_n = ADDR_WIDTH'(8'h31); end
        default: ;
      endcase
  end
  // job latch, counters, captured read data and registered bus outputs
  always_ff @(posedge clk)
    if (rst) begin
      {img_w, img_h, scale, in_words, out_pix, wcnt, pcnt, cnt} <= '0;
      tcnt <= '0;
      {err, out_valid, out_data, perf_cyc, perf_pix} <= '0;
      {h_wr_en, h_rd_en, h_addr, h_wdata} <= '0;
    end else begin
      cnt <= state_n != state ? 16'd0 : cnt + 16'(cnt != 16'hFFFF);
      tcnt <= in_poll ? tcnt + TW'(1) : '0;
      if (state == S_IDLE && job_start) begin
        {img_w, img_h, scale, in_words, out_pix} <= {job_img_w, job_img_h, job_scale, job_in_words, job_out_pix};
        {wcnt, pcnt, perf_cyc, perf_pix} <= '0;
        err <= 1'b0;
      end
      if (tout) err <= 1'b1;
      if (state == S_IN_WAIT && in_valid) wcnt <= wcnt + 16'd1;
      if (state == S_CYC_RD && cap) perf_cyc <= h_rdata;
      if (state == S_PIX_RD && cap) perf_pix <= h_rdata;
      if (state == S_OUT_RD && cap_o) begin
        out_valid <= 1'b1;
        out_data <= h_rdata[7:0];
      end
      if (state == S_OUT_HOLD && out_ready) begin
        out_valid <= 1'b0;
        pcnt <= pcnt + 16'd1;
      end
      {h_wr_en, h_rd_en, h_addr, h_wdata} <= {wr_n, rd_n, addr_n, wdata_n};
    end
endmodule

// File: tb/tb_dsa_host_seq.sv
// tb_dsa_host_seq: directed jobs against a reactive register-slave model with a transaction-level scoreboard
module tb_dsa_host_seq;
  localparam int IN_GAP = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic job_start = 1'b0;
  logic [15:0] job_img_w = '0, job_img_h = '0, job_scale = '0, job_in_words = '0, job_out_pix = '0;
  logic in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic in_ready, out_valid, out_ready, busy, done, err, h_wr_en, h_rd_en;
  logic [7:0] out_data;
  logic [31:0] perf_cyc, perf_pix, h_wdata;
  logic [15:0] h_addr;
  logic [31:0] h_rdata = '0;
  logic h_rvalid = 1'b0;
  logic sl_clr = 1'b0, never_done = 1'b0, tog_en = 1'b0;
  logic primed = 1'b0;
  int polls = 0, opix = 0;
  int checks = 0, failures = 0;
  typedef struct {bit wr; logic [15:0] a; logic [31:0] d; int tag;} tr_t;
  tr_t exp_q[$];
  logic [7:0] pixq[$];
  bit mon_en = 0, allow_status = 0;
  int cyc = 0, last_cyc = 0, last_in = 0, done_cyc = 0, npix = 0;
  logic [7:0] first_pix = '0, last_pix = '0;

  dsa_host_seq #(.TIMEOUT(256)) dut (
    .clk(clk), .rst(rst), .job_start(job_start), .job_img_w(job_img_w), .job_img_h(job_img_h),
    .job_scale(job_scale), .job_in_words(job_in_words), .job_out_pix(job_out_pix),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy), .done(done), .err(err),
    .perf_cyc(perf_cyc), .perf_pix(perf_pix), .h_wr_en(h_wr_en), .h_rd_en(h_rd_en),
    .h_addr(h_addr), .h_wdata(h_wdata), .h_rdata(h_rdata), .h_rvalid(h_rvalid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input int i);
    return 32'h0403_0201 + 32'(i) * 32'h0404_0404;
  endfunction

  function automatic logic [7:0] pix(input int k);
    return 8'h10 + 8'(3 * k);
  endfunction

  // register slave: CSR reads alternate prime (garbage) / capture (real value), data one cycle after strobe
  always @(posedge clk) begin
    h_rvalid <= 1'b0;
    if (rst || sl_clr) begin
      primed <= 1'b0;
      polls <= 0;
      opix <= 0;
    end else if (h_rd_en) begin
      h_rvalid <= 1'b1;
      if (h_addr == 16'h31) begin
        h_rdata <= {24'hABCDEF, pix(opix)};
        opix <= opix + 1;
      end else if (!primed) begin
        primed <= 1'b1;
        h_rdata <= 32'hFFFF_FFFF;
      end else begin
        primed <= 1'b0;
        h_rdata <= h_addr == 16'h01 ? ((never_done || polls < 2) ? 32'h1 : 32'h3) :
                   h_addr == 16'h06 ? 32'h1234_5678 : h_addr == 16'h07 ? 32'h0000_0040 : 32'h0;
        if (h_addr == 16'h01) polls <= polls + 1;
      end
    end
  end

  // consumer backpressure: toggles every cycle when enabled, otherwise always ready
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      out_ready = tog_en ? ~out_ready : 1'b1;
    end
  end

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask

  task automatic push(input bit wr, input logic [15:0] a, input logic [31:0] d, input int tag);
    tr_t t;
    t.wr = wr; t.a = a; t.d = d; t.tag = tag;
    exp_q.push_back(t);
  endtask

  // expected bus transaction list for one job; tag 1 = back-to-back, 2 = IN_DATA spacing, 3 = capture after prime
  task automatic build(input logic [15:0] w, h, s, iw, op, input int npolls);
    exp_q.delete();
    pixq.delete();
    push(1, 16'h02, {16'd0, w}, 0);
    push(1, 16'h03, {16'd0, h}, 1);
    push(1, 16'h04, {16'd0, s}, 1);
    push(1, 16'h20, 32'd0, 1);
    for (int i = 0; i < int'(iw); i++) push(1, 16'h21, word(i), i == 0 ? 0 : 2);
    push(1, 16'h00, 32'd1, 0);
    if (npolls < 0) return;
    for (int p = 0; p < npolls; p++) begin
      push(0, 16'h01, 32'd0, 0);
      push(0, 16'h01, 32'd0, 3);
    end
    push(0, 16'h06, 32'd0, 0);
    push(0, 16'h06, 32'd0, 3);
    push(0, 16'h07, 32'd0, 0);
    push(0, 16'h07, 32'd0, 3);
    push(1, 16'h30, 32'd0, 0);
    for (int k = 0; k < int'(op); k++) begin
      push(0, 16'h31, 32'd0, 0);
      pixq.push_back(pix(k));
    end
  endtask

  task automatic monitor();
    tr_t t;
    logic [7:0] p;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (h_wr_en || h_rd_en) chk("both_strobes", 64'(h_wr_en & h_rd_en), 0);
        if (mon_en && (h_wr_en || h_rd_en)) begin
          if (exp_q.size() == 0) chk("extra_bus_cycle", 64'(allow_status && h_rd_en && h_addr == 16'h01), 1);
          else begin
            t = exp_q.pop_front();
            chk("bus_kind_wr", 64'(h_wr_en), 64'(t.wr));
            chk("bus_addr", 64'(h_addr), 64'(t.a));
            if (t.wr) chk("bus_wdata", 64'(h_wdata), 64'(t.d));
            if (t.tag == 1) chk("config_consecutive", 64'(cyc - last_cyc), 1);
            if (t.tag == 2) chk("in_gap_respected", 64'((cyc - last_in) >= IN_GAP + 1), 1);
            if (t.tag == 3) chk("idle_between_prime_capture", 64'((cyc - last_cyc) >= 2), 1);
          end
          last_cyc = cyc;
          if (h_wr_en && h_addr == 16'h21) last_in = cyc;
        end
        if (mon_en && h_rd_en) chk("rd_while_pixel_pending", 64'(h_addr == 16'h31 && out_valid), 0);
        if (mon_en && out_valid && out_ready) begin
          chk("pixel_expected", 64'(pixq.size() > 0), 1);
          if (pixq.size() > 0) begin
            p = pixq.pop_front();
            chk("pixel_value", 64'(out_data), 64'(p));
            npix++;
            if (npix == 1) first_pix = out_data;
            last_pix = out_data;
          end
        end
        if (done) done_cyc++;
      end
    end
  endtask

  task automatic start(input logic [15:0] w, h, s, iw, op);
    job_img_w = w; job_img_h = h; job_scale = s; job_in_words = iw; job_out_pix = op;
    job_start = 1'b1;
    @(posedge clk);
    #1;
    job_start = 1'b0;
  endtask

  task automatic clear_slave();
    sl_clr = 1'b1;
    @(posedge clk);
    #1;
    sl_clr = 1'b0;
  endtask

  task automatic feed(input int n);
    int b;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data = word(i);
      b = 0;
      do begin
        @(negedge clk);
        b++;
      end while (!in_ready && b < 200);
      if (!in_ready) begin
        chk("feed_accept_timeout", 64'(in_ready), 1);
        break;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int b = 0;
    while (busy && b < maxc) begin
      @(negedge clk);
      b++;
    end
    chk("job_ended_in_budget", 64'(busy), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, 64'({in_ready, out_valid, busy, done, err, h_wr_en, h_rd_en}), 0);
    chk({tag, "_addr"}, 64'(h_addr), 0);
    chk({tag, "_wdata"}, 64'(h_wdata), 0);
    chk({tag, "_out_data"}, 64'(out_data), 0);
    chk({tag, "_perf"}, {perf_cyc, perf_pix}, 0);
  endtask

  initial begin
    int n, b;
    fork monitor(); join_none
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    // main job: config, 16 words, 3 polls, perf, 16 pixels with 50% backpressure
    clear_slave();
    never_done = 1'b0;
    done_cyc = 0; npix = 0;
    build(16'd8, 16'd8, 16'h0080, 16'd16, 16'd16, 3);
    mon_en = 1; tog_en = 1'b1;
    start(16'd8, 16'd8, 16'h0080, 16'd16, 16'd16);
    job_img_w = 16'd99; job_in_words = 16'd2; job_out_pix = 16'd1;
    job_start = 1'b1;
    @(posedge clk);
    #1;
    job_start = 1'b0;
    feed(16);
    wait_idle(3000);
    chk("jobA_done_cycles", 64'(done_cyc), 1);
    chk("jobA_err", 64'(err), 0);
    chk("jobA_perf_cyc", 64'(perf_cyc), 64'h1234_5678);
    chk("jobA_perf_pix", 64'(perf_pix), 64'h40);
    chk("jobA_bus_left", 64'(exp_q.size()), 0);
    chk("jobA_pixels", 64'(npix), 16);
    chk("jobA_first_pix", 64'(first_pix), 64'h10);
    chk("jobA_last_pix", 64'(last_pix), 64'h3D);
    // reset in the middle of input streaming
    mon_en = 0; tog_en = 1'b0;
    clear_slave();
    start(16'd8, 16'd8, 16'h0080, 16'd4, 16'd4);
    in_valid = 1'b1;
    in_data = 32'h55AA_55AA;
    n = 0; b = 0;
    while (n < 2 && b < 200) begin
      @(negedge clk);
      b++;
      if (h_wr_en && h_addr == 16'h21) n++;
    end
    chk("midjob_in_writes_seen", 64'(n), 2);
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk_zero("midjob_reset");
    rst = 1'b0;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (h_wr_en || h_rd_en) n++;
    end
    chk("midjob_no_bus_after_reset", 64'(n), 0);
    chk("midjob_busy", 64'(busy), 0);
    // poll timeout: STATUS never reports DONE
    never_done = 1'b1;
    clear_slave();
    build(16'h20, 16'h10, 16'h0100, 16'd0, 16'd0, -1);
    allow_status = 1; mon_en = 1; done_cyc = 0;
    start(16'h20, 16'h10, 16'h0100, 16'd0, 16'd0);
    wait_idle(2000);
    chk("timeout_err", 64'(err), 1);
    chk("timeout_busy", 64'(busy), 0);
    chk("timeout_no_done", 64'(done_cyc), 0);
    chk("timeout_bus_left", 64'(exp_q.size()), 0);
    allow_status = 0;
    repeat (10) @(negedge clk);
    chk("timeout_err_sticky", 64'(err), 1);
    // recovery job with no input words and no output pixels
    never_done = 1'b0;
    clear_slave();
    build(16'd640, 16'd480, 16'h0180, 16'd0, 16'd0, 3);
    done_cyc = 0; npix = 0;
    start(16'd640, 16'd480, 16'h0180, 16'd0, 16'd0);
    chk("err_cleared_by_start", 64'(err), 0);
    chk("recovery_busy", 64'(busy), 1);
    wait_idle(2000);
    chk("recovery_done_cycles", 64'(done_cyc), 1);
    chk("recovery_err", 64'(err), 0);
    chk("recovery_bus_left", 64'(exp_q.size()), 0);
    chk("recovery_perf_cyc", 64'(perf_cyc), 64'h1234_5678);
    chk("recovery_pixels", 64'(npix), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
